// File: rtl/pipe_mux_reg.sv
// rtl/pipe_mux_reg.sv - N:1 operand select with registered output, 2-entry skid buffer and flush
module pipe_mux_reg #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = $clog2(NUM_IN),
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_CNT_W-1:0]    err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       main_data_q, main_data_d;
    logic                   main_err_q, main_err_d;
    logic [WIDTH-1:0]       skid_data_q, skid_data_d;
    logic                   skid_err_q, skid_err_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]       beat_data;
    logic                   beat_err;
    logic                   in_fire;
    logic                   out_fire;

    // Out-of-range selects fall back to slice 0 and are flagged on the beat.
    always_comb begin
        beat_err  = ({1'b0, sel} >= NUM_IN_W);
        beat_data = in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                beat_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready    = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = main_data_q;
    assign out_sel_err = main_err_q;
    assign err_count   = err_count_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        err_count_d = err_count_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = ONE;
                    main_data_d = beat_data;
                    main_err_d  = beat_err;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = beat_data;
                    main_err_d  = beat_err;
                end else if (in_fire) begin
                    state_d     = FULL;
                    skid_data_d = beat_data;
                    skid_err_d  = beat_err;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Data registers may still load here; with state EMPTY they are invisible.
        if (flush) begin
            state_d = EMPTY;
        end

        if (in_fire && beat_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb/tb_pipe_mux_reg.sv - directed vector bench for pipe_mux_reg (NUM_IN=4 and NUM_IN=3 instances)
module tb_pipe_mux_reg;

    localparam logic [31:0] SA = 32'hAAAA_0000;
    localparam logic [31:0] SB = 32'hBBBB_0001;
    localparam logic [31:0] SC = 32'hCCCC_0002;
    localparam logic [31:0] SD = 32'hDDDD_0003;
    localparam logic [31:0] T0 = 32'h3030_0000;
    localparam logic [31:0] T1 = 32'h3131_0001;
    localparam logic [31:0] T2 = 32'h3232_0002;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [127:0] in_data4;
    logic [1:0]   sel4;
    logic         in_valid4, in_ready4, flush4, out_sel_err4, out_valid4, out_ready4;
    logic [31:0]  out_data4;
    logic [7:0]   err_count4;

    logic [95:0]  in_data3;
    logic [1:0]   sel3;
    logic         in_valid3, in_ready3, flush3, out_sel_err3, out_valid3, out_ready3;
    logic [31:0]  out_data3;
    logic [7:0]   err_count3;

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(4), .ERR_CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .flush(flush4),
        .out_data(out_data4), .out_sel_err(out_sel_err4), .out_valid(out_valid4),
        .out_ready(out_ready4), .err_count(err_count4)
    );

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_sel_err(out_sel_err3), .out_valid(out_valid3),
        .out_ready(out_ready3), .err_count(err_count3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic        er;
    } vec_t;

    vec_t vecs[18];

    task automatic beat3(input logic iv, input logic [1:0] s, input logic fl);
        @(negedge clk);
        in_valid3 = iv;
        sel3      = s;
        flush3    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = '{
            // pass-through
            '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, SC, 1'b1},
            '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1},
            // back-pressure: 0,1 fill, 3 held upstream, then drain in order
            '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, SA, 1'b1},
            '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, SA, 1'b0},
            '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, SA, 1'b0},
            '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, SB, 1'b1},
            '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, SB, 1'b0},
            '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, SD, 1'b1},
            '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1},
            // flush from FULL with a beat offered
            '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, SA, 1'b1},
            '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, SA, 1'b0},
            '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1},
            '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1},
            // flush from EMPTY discards an accepted beat
            '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1},
            '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1},
            // simultaneous accept and drain in ONE
            '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, SB, 1'b1},
            '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, SC, 1'b1},
            '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1}
        };

        rst_n      = 1'b0;
        in_data4   = {SD, SC, SB, SA};
        sel4       = '0;
        in_valid4  = 1'b0;
        flush4     = 1'b0;
        out_ready4 = 1'b0;
        in_data3   = {T2, T1, T0};
        sel3       = '0;
        in_valid3  = 1'b0;
        flush3     = 1'b0;
        out_ready3 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid4), 32'd0);
        chk("reset out_data", out_data4, 32'h0);
        chk("reset err_count", 32'(err_count4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset in_ready", 32'(in_ready4), 32'd1);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid4  = vecs[i].iv;
            sel4       = vecs[i].sel;
            out_ready4 = vecs[i].ordy;
            flush4     = vecs[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid4), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d out_data", i), out_data4, vecs[i].ed);
                chk($sformatf("vec%0d out_sel_err", i), 32'(out_sel_err4), 32'd0);
            end
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready4), 32'(vecs[i].er));
        end
        chk("u4 err_count", 32'(err_count4), 32'd0);

        // streaming: 16 beats back-to-back with unique data per beat
        for (int b = 0; b <= 16; b++) begin
            @(negedge clk);
            in_valid4  = (b < 16);
            sel4       = 2'(b % 4);
            out_ready4 = 1'b1;
            flush4     = 1'b0;
            for (int j = 0; j < 4; j++) in_data4[j*32 +: 32] = {16'(b), 16'(j)};
            if (b < 16) chk($sformatf("stream%0d in_ready", b), 32'(in_ready4), 32'd1);
            @(posedge clk);
            #1;
            if (b < 16) begin
                chk($sformatf("stream%0d out_valid", b), 32'(out_valid4), 32'd1);
                chk($sformatf("stream%0d out_data", b), out_data4, {16'(b), 16'(b % 4)});
            end else begin
                chk("stream end out_valid", 32'(out_valid4), 32'd0);
            end
        end
        in_data4 = {SD, SC, SB, SA};

        // out-of-range select on the 3-input instance
        beat3(1'b1, 2'd3, 1'b0);
        chk("oor out_valid", 32'(out_valid3), 32'd1);
        chk("oor out_data", out_data3, T0);
        chk("oor out_sel_err", 32'(out_sel_err3), 32'd1);
        chk("oor err_count", 32'(err_count3), 32'd1);
        beat3(1'b1, 2'd3, 1'b1);
        chk("oor flush out_valid", 32'(out_valid3), 32'd0);
        chk("oor flush err_count", 32'(err_count3), 32'd2);
        beat3(1'b1, 2'd1, 1'b0);
        chk("in-range out_data", out_data3, T1);
        chk("in-range out_sel_err", 32'(out_sel_err3), 32'd0);
        chk("in-range err_count", 32'(err_count3), 32'd2);
        for (int n = 0; n < 300; n++) beat3(1'b1, 2'd3, 1'b0);
        chk("err_count saturated", 32'(err_count3), 32'd255);
        beat3(1'b1, 2'd3, 1'b0);
        chk("err_count holds", 32'(err_count3), 32'd255);
        beat3(1'b0, 2'd0, 1'b0);

        // fill u4 to FULL, then reset asynchronously between edges
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            in_valid4  = 1'b1;
            sel4       = 2'(n);
            out_ready4 = 1'b0;
            @(posedge clk);
        end
        #1;
        chk("pre-reset in_ready full", 32'(in_ready4), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid4), 32'd0);
        chk("async reset in_ready", 32'(in_ready4), 32'd1);
        chk("async reset err_count", 32'(err_count3), 32'd0);
        in_valid4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid4  = 1'b1;
        sel4       = 2'd3;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        chk("resume out_valid", 32'(out_valid4), 32'd1);
        chk("resume out_data", out_data4, SD);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        chk("resume drain", 32'(out_valid4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
